// File: rtl/fpadd_seq_param.sv
// fpadd_seq_param
// ---------------------------------------------------------------------------
// Multi-cycle parametrised floating-point adder/subtractor with round to
// nearest, ties to even. Each operation runs through a fixed six-state
// sequence: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE. Every operation
// takes the same number of cycles, including the special cases.
//
// Handshake:
//   An operation is accepted on a rising edge where in_valid && in_ready.
//   A result is consumed on a rising edge where out_valid && out_ready.
//   in_ready is high only in IDLE. out_valid is high only in DONE. Both are
//   registered. in_valid outside IDLE is ignored. sum and flags stay stable
//   while out_valid is high.
//
// Ports:
//   clock, nreset     rising-edge clock; asynchronous active-low reset
//   in_valid/ready    operand handshake
//   a, b              operands {sign, exp[EXP_W], man[MAN_W]}
//   sub               1: a-b, 0: a+b
//   out_valid/ready   result handshake
//   sum               result
//   flags             {invalid, overflow, inexact}
//
// Build option:
//   FPADD_STATUS_EN   when defined, flags reports the status bits. When
//                     undefined, flags is tied to 3'b000. sum, the handshake
//                     and the latency are the same in both builds.
//
// Inputs with exp==0 are flushed to zero. Results that would underflow are
// flushed to signed zero.
// ---------------------------------------------------------------------------
module fpadd_seq_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] sum,
  output logic [2:0]           flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  // Working mantissa: hidden bit, fraction, then guard/round/sticky.
  localparam int MW  = MAN_W + 4;
  localparam int LZW = $clog2(MW + 1);

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef FPADD_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // ------------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      sum_q, sum_d;
  logic [2:0]        flags_q, flags_d;

  logic [W-1:0]      opa_q, opa_d;      // operand A as captured
  logic [W-1:0]      opb_q, opb_d;      // operand B with the sub inversion applied
  logic              sign_q, sign_d;    // sign of the larger-magnitude operand
  logic              eff_sub_q, eff_sub_d;
  logic [EXP_W-1:0]  exp_q, exp_d;      // exponent of the larger operand
  logic [MW-1:0]     big_q, big_d;
  logic [MW-1:0]     small_q, small_d;  // already aligned to big_q
  logic [MW:0]       add_q, add_d;
  logic [MW-1:0]     norm_m_q, norm_m_d;
  logic [EXP_W:0]    norm_e_q, norm_e_d;
  // A special result (NaN, inf, zero, underflow) bypasses the later stages.
  logic              spec_q, spec_d;
  logic [W-1:0]      spec_sum_q, spec_sum_d;
  logic [2:0]        spec_flags_q, spec_flags_d;

  // ------------------------------------------------------------------------
  // ALIGN: unpack operands, detect special cases, order operands, shift
  // ------------------------------------------------------------------------
  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [MAN_W-1:0]  ma, mb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [MW-1:0]     mant_a, mant_b;
  logic              a_ge_b;

  assign sa = opa_q[W-1];
  assign ea = opa_q[W-2:MAN_W];
  assign ma = opa_q[MAN_W-1:0];
  assign sb = opb_q[W-1];
  assign eb = opb_q[W-2:MAN_W];
  assign mb = opb_q[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);
  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);

  // A flushed input has no hidden bit and no fraction.
  assign mant_a = a_zero ? '0 : {1'b1, ma, 3'b000};
  assign mant_b = b_zero ? '0 : {1'b1, mb, 3'b000};

  // When the exponents match, this compare orders by fraction. A flushed
  // operand has exp 0, so its fraction bits never win against a nonzero one.
  assign a_ge_b = {ea, ma} >= {eb, mb};

  logic              al_sign;
  logic [EXP_W-1:0]  al_exp;
  logic [MW-1:0]     al_big, al_small_raw, al_small, al_lost;
  logic [31:0]       al_diff;

  always_comb begin
    al_sign      = a_ge_b ? sa : sb;
    al_exp       = a_ge_b ? ea : eb;
    al_big       = a_ge_b ? mant_a : mant_b;
    al_small_raw = a_ge_b ? mant_b : mant_a;
    al_diff      = a_ge_b ? (32'(ea) - 32'(eb)) : (32'(eb) - 32'(ea));
    al_lost      = '0;
    if (al_diff >= 32'(MW - 1)) begin
      // Shifted completely past the guard and round bits: only sticky remains.
      al_small = {{(MW-1){1'b0}}, |al_small_raw};
    end else begin
      al_small    = al_small_raw >> al_diff;
      al_lost     = al_small_raw & ~({MW{1'b1}} << al_diff);
      al_small[0] = al_small[0] | (|al_lost);
    end
  end

  logic              sp_hit;
  logic [W-1:0]      sp_sum;
  logic [2:0]        sp_flags;

  always_comb begin
    sp_hit   = 1'b1;
    sp_sum   = '0;
    sp_flags = 3'b000;
    if (a_nan || b_nan) begin
      sp_sum   = QNAN;
      sp_flags = 3'b100;
    end else if (a_inf && b_inf && (sa != sb)) begin
      sp_sum   = QNAN;
      sp_flags = 3'b100;
    end else if (a_inf) begin
      sp_sum = opa_q;
    end else if (b_inf) begin
      sp_sum = opb_q;
    end else if (a_zero && b_zero) begin
      // Only two negative zeros give -0.
      sp_sum = {sa & sb, {(W-1){1'b0}}};
    end else begin
      sp_hit = 1'b0;
    end
  end

  // ------------------------------------------------------------------------
  // ADD: big_q >= small_q always holds, so the difference is never negative
  // ------------------------------------------------------------------------
  logic [MW:0] add_res;
  assign add_res = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                             : ({1'b0, big_q} + {1'b0, small_q});

  // ------------------------------------------------------------------------
  // NORM: leading-zero count and shift
  // ------------------------------------------------------------------------
  function automatic logic [LZW-1:0] lzc_f(input logic [MW-1:0] v);
    logic           found;
    logic [LZW-1:0] n;
    found = 1'b0;
    n     = '0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 1'b1;
      end
    end
    return n;
  endfunction

  logic [LZW-1:0] nm_lz;
  logic           nm_zero, nm_carry, nm_uflow;
  logic [MW-1:0]  nm_m;
  logic [EXP_W:0] nm_e;
  logic [31:0]    nm_sub32;

  always_comb begin
    nm_lz    = lzc_f(add_q[MW-1:0]);
    nm_zero  = (add_q == '0);
    nm_carry = add_q[MW];
    nm_sub32 = 32'(exp_q) - 32'(nm_lz);
    // The exponent after the left shift would fall below 1.
    nm_uflow = ($signed(nm_sub32) < 32'sd1);
    if (nm_carry) begin
      // Shift right by one. The bit shifted out is folded into sticky.
      nm_m = {add_q[MW:2], add_q[1] | add_q[0]};
      nm_e = {1'b0, exp_q} + 1'b1;
    end else begin
      nm_m = add_q[MW-1:0] << nm_lz;
      nm_e = nm_sub32[EXP_W:0];
    end
  end

  // ------------------------------------------------------------------------
  // ROUND: round to nearest, ties to even, then check for overflow
  // ------------------------------------------------------------------------
  logic [MAN_W:0]   rd_keep;
  logic             rd_g, rd_r, rd_s, rd_up, rd_ovf, rd_inexact;
  logic [MAN_W+1:0] rd_sum;
  logic [EXP_W:0]   rd_e;
  logic [MAN_W-1:0] rd_frac;
  logic [W-1:0]     res_sum;
  logic [2:0]       res_flags;

  always_comb begin
    rd_keep    = norm_m_q[MW-1:3];
    rd_g       = norm_m_q[2];
    rd_r       = norm_m_q[1];
    rd_s       = norm_m_q[0];
    rd_up      = rd_g & (rd_r | rd_s | rd_keep[0]);
    rd_sum     = {1'b0, rd_keep} + {{(MAN_W+1){1'b0}}, rd_up};
    rd_ovf     = rd_sum[MAN_W+1];
    rd_e       = rd_ovf ? (norm_e_q + 1'b1) : norm_e_q;
    rd_frac    = rd_ovf ? rd_sum[MAN_W:1] : rd_sum[MAN_W-1:0];
    rd_inexact = rd_g | rd_r | rd_s;
    if (spec_q) begin
      res_sum   = spec_sum_q;
      res_flags = spec_flags_q;
    end else if (rd_e >= {1'b0, EXP_ONES}) begin
      res_sum   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      res_flags = 3'b011;
    end else begin
      res_sum   = {sign_q, rd_e[EXP_W-1:0], rd_frac};
      res_flags = {2'b00, rd_inexact};
    end
  end

  // ------------------------------------------------------------------------
  // Next-state and datapath register updates
  // ------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    flags_d      = flags_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    sign_d       = sign_q;
    eff_sub_d    = eff_sub_q;
    exp_d        = exp_q;
    big_d        = big_q;
    small_d      = small_q;
    add_d        = add_q;
    norm_m_d     = norm_m_q;
    norm_e_d     = norm_e_q;
    spec_d       = spec_q;
    spec_sum_d   = spec_sum_q;
    spec_flags_d = spec_flags_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          opa_d   = a;
          opb_d   = {b[W-1] ^ sub, b[W-2:0]};
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        sign_d       = al_sign;
        eff_sub_d    = sa ^ sb;
        exp_d        = al_exp;
        big_d        = al_big;
        small_d      = al_small;
        spec_d       = sp_hit;
        spec_sum_d   = sp_sum;
        spec_flags_d = sp_flags;
        state_d      = S_ADD;
      end
      S_ADD: begin
        add_d   = add_res;
        state_d = S_NORM;
      end
      S_NORM: begin
        if (!spec_q) begin
          if (nm_zero) begin
            // Exact cancellation of nonzero operands gives +0.
            spec_d       = 1'b1;
            spec_sum_d   = '0;
            spec_flags_d = 3'b000;
          end else if (!nm_carry && nm_uflow) begin
            spec_d       = 1'b1;
            spec_sum_d   = {sign_q, {(W-1){1'b0}}};
            spec_flags_d = 3'b001;
          end else begin
            norm_m_d = nm_m;
            norm_e_d = nm_e;
          end
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        sum_d   = res_sum;
        flags_d = STATUS_EN ? res_flags : 3'b000;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      sum_q        <= '0;
      flags_q      <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      sign_q       <= 1'b0;
      eff_sub_q    <= 1'b0;
      exp_q        <= '0;
      big_q        <= '0;
      small_q      <= '0;
      add_q        <= '0;
      norm_m_q     <= '0;
      norm_e_q     <= '0;
      spec_q       <= 1'b0;
      spec_sum_q   <= '0;
      spec_flags_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      sum_q        <= sum_d;
      flags_q      <= flags_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      sign_q       <= sign_d;
      eff_sub_q    <= eff_sub_d;
      exp_q        <= exp_d;
      big_q        <= big_d;
      small_q      <= small_d;
      add_q        <= add_d;
      norm_m_q     <= norm_m_d;
      norm_e_q     <= norm_e_d;
      spec_q       <= spec_d;
      spec_sum_q   <= spec_sum_d;
      spec_flags_q <= spec_flags_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fpadd_seq_param.sv
// Directed bench for fpadd_seq_param at the default single-precision
// parameters. Expected sums and flags are hand-computed constants. When
// FPADD_STATUS_EN is undefined, every expected flag value is masked to 000.
`timescale 1ns/1ps
module tb_fpadd_seq_param;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;

`ifdef FPADD_STATUS_EN
  localparam logic [2:0] FMASK = 3'b111;
`else
  localparam logic [2:0] FMASK = 3'b000;
`endif

  logic         clock = 1'b0;
  logic         nreset;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic [2:0]   flags;

  // Scoreboard entries are {flags, sum}.
  logic [W+2:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  fpadd_seq_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .flags     (flags)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // ---------------- driver ----------------
  // This task is entered and left 1ns after a rising edge, in IDLE.
  // hold > 0 keeps out_ready low in DONE for that many cycles and pokes in_valid.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input logic [W-1:0] es, input logic [2:0] ef,
                        input int hold);
    int           cyc;
    logic [W+2:0] e;
    exp_q.push_back({ef & FMASK, es});
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clock); #1; cyc++;
    end
    check({tag, " accept"}, 64'(in_ready), 64'd1);
    @(posedge clock); #1;             // accepting edge is counted as cycle 1
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clock); #1; cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'd5);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 32'h40800000; b = 32'h40800000;
      @(posedge clock); #1;
      check({tag, " hold sum"}, 64'(sum), 64'(e[W-1:0]));
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
      check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0; a = '0; b = '0;
    check({tag, " sum"}, 64'(sum), 64'(e[W-1:0]));
    check({tag, " flags"}, 64'(flags), 64'(e[W+2:W]));
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({tag, " release out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " release in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stray;
    nreset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset flags", 64'(flags), 64'd0);
    #4 nreset = 1'b1;
    @(posedge clock); #1;

    //      tag            a             b             sub   sum           flags  hold
    run_op("1+2",         32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 0);
    run_op("1-1",         32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 0);
    run_op("inf-inf",     32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, 0);
    run_op("nan+1",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, 0);
    run_op("max+max",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 0);
    run_op("tie even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 0);
    run_op("tie odd",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, 0);
    run_op("2-1",         32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000, 0);
    run_op("-0+-0",       32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 0);
    run_op("+0+-0",       32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000, 0);
    run_op("inf+1",       32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, 0);
    run_op("-inf-2",      32'hFF800000, 32'h40000000, 1'b1, 32'hFF800000, 3'b000, 0);
    run_op("-2+1",        32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000, 0);
    run_op("1-3",         32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 3'b000, 0);
    run_op("underflow",   32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001, 0);
    run_op("denorm+1",    32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000, 0);
    run_op("far sticky",  32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b001, 0);

    // A result held in DONE while a new in_valid is presented.
    run_op("hold",        32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 3);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (out_valid) stray++;
    end
    check("ignored op no output", 64'(stray), 64'd0);

    // Reset asserted while the operation is in NORM.
    a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;             // accept -> ALIGN
    in_valid = 1'b0;
    @(posedge clock);                 // -> ADD
    @(posedge clock);                 // -> NORM
    #2 nreset = 1'b0;
    #1;
    check("mid reset in_ready", 64'(in_ready), 64'd1);
    check("mid reset out_valid", 64'(out_valid), 64'd0);
    check("mid reset sum", 64'(sum), 64'd0);
    check("mid reset flags", 64'(flags), 64'd0);
    #4 nreset = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (out_valid) stray++;
    end
    check("discarded op no output", 64'(stray), 64'd0);
    run_op("after reset", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000, 0);

    check("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpadd_seq_param.md
Name: fpadd_seq_param

Overview:
Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor with valid/ready handshakes on input and output.
- Generalises the team's fixed 32-bit sequential adder in three ways: configurable exponent and mantissa widths, parallel operand capture, and an add/subtract mode bit.
- Full special-case handling and round-to-nearest-even.
- Sits between the operand-fetch stage and the result writeback in the FP datapath.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored mantissa field width, hidden bit excluded (>=2)

Ports:
clock  input  1  system clock, rising edge
nreset  input  1  asynchronous, active-low reset
in_valid  input  1  operands and mode valid
in_ready  output  1  block can accept an operation
a  input  1+EXP_W+MAN_W  operand A {sign, exp, man}
b  input  1+EXP_W+MAN_W  operand B
sub  input  1  1: compute a-b; 0: compute a+b
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  1+EXP_W+MAN_W  result
flags  output  3  {invalid, overflow, inexact}

Behaviour:
- Reset: clock is clock; reset nreset is asynchronous, active-low.
  - Asserting nreset forces state IDLE, in_ready=1, out_valid=0, sum=0, flags=0.
  - Internal registers are cleared.
  - Any in-flight operation is discarded with no output.
- States and transitions: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register a, b, and sub. When sub=1, b's sign is inverted.
  - Go to ALIGN.
- ALIGN:
  - Unpack both operands; prepend the hidden bit (0 if exp==0).
  - Inputs with exp==0 are treated as zero (flush-to-zero).
  - Order operands by magnitude.
  - Right-shift the smaller mantissa by the exponent difference, keeping guard, round, and sticky bits.
  - A shift >= MAN_W+3 leaves only sticky.
- ADD:
  - Add mantissas when signs are equal; otherwise subtract. Width is MAN_W+4 bits plus a carry bit.
  - Result sign is the sign of the larger-magnitude operand.
- NORM:
  - On carry-out, right-shift 1 (OR the lost bit into sticky) and increment the exponent.
  - Otherwise, left-shift by the leading-zero count (combinational LZC) and decrement the exponent.
  - If the exponent would drop below 1, the result flushes to signed zero and inexact is set.
- ROUND:
  - Round to nearest, ties to even, using guard/round/sticky.
  - A mantissa overflow from rounding increments the exponent.
  - Exponent >= all-ones gives signed infinity, with overflow=1 and inexact=1.
  - inexact=1 whenever any of G/R/S is nonzero.
- DONE:
  - out_valid=1; sum and flags are stable.
  - Hold until out_ready=1, then go to IDLE. in_ready rises on the next cycle.
- Latency: out_valid asserts exactly 5 cycles after the accepting edge. Throughput is 1 operation per 6 cycles minimum.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored.
- Special cases are resolved in ALIGN; the result is carried to DONE with the same fixed latency.
  - Either operand NaN: canonical qNaN (sign 0, exp all ones, mantissa MSB 1, rest 0), invalid=1.
  - inf + (-inf) after sub adjustment: canonical qNaN, invalid=1.
  - inf + finite: that infinity, flags 0.
  - Exact cancellation of nonzero operands: +0.
  - (-0)+(-0): -0. (+0)+(-0): +0.
- sum and flags are registered outputs and change only when entering DONE or on reset.

Optional Feature:
FPADD_STATUS_EN
- Defined: flags is computed as specified above.
- Undefined: the flag logic is removed and flags is driven constant 3'b000.
- sum, handshake, and latency are identical in both builds.

Test Plan:
- Defaults, a=3F800000, b=40000000, sub=0 -> sum=40400000, flags=000, out_valid exactly 5 cycles after accept.
- a=3F800000, b=3F800000, sub=1 -> sum=00000000 (+0), flags=000.
- a=7F800000, b=7F800000, sub=1 -> sum=7FC00000, invalid=1. a=7FC00001 with any b -> 7FC00000, invalid=1.
- a=7F7FFFFF, b=7F7FFFFF, sub=0 -> sum=7F800000, overflow=1, inexact=1.
- a=3F800000, b=33800000 (tie) -> sum=3F800000, inexact=1. a=3F800001, b=33800000 -> sum=3F800002, inexact=1.
- Handshake and reset:
  - Hold out_ready=0 for 3 cycles in DONE -> sum held stable, in_ready=0, new in_valid ignored.
  - Pulse nreset low during NORM -> outputs return to reset values; the next operation completes correctly.
